// File: rtl/psram_if_pkg.sv
// Shared constants, FSM encoding and command record for the PSRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psram_if_pkg;

  // Fixed part of the busy period for each command type
  localparam int unsigned WR_BASE = 3;
  localparam int unsigned RD_BASE = 8;

  // FSM state encoding
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  // Write-side attributes captured at command acceptance
  typedef struct packed {
    logic        byte_wr;
    logic        lane;
    logic [15:0] din;
  } cmd_t;

  // Busy length in cycles: base + LATENCY * (1 or 2)
  function automatic logic [23:0] busy_len(input int unsigned lat, input logic k2,
                                           input logic is_wr);
    int unsigned base;
    int unsigned mult;
    base = is_wr ? WR_BASE : RD_BASE;
    mult = k2 ? 2 : 1;
    return 24'(base + lat * mult);
  endfunction

endpackage

// File: rtl/bram_be16.sv
// Single-port 2**AW x 16 synchronous RAM with per-byte write enables.
// Latency: write lands at the clock edge; read data registered, valid one cycle after i_re.
// Backpressure: none; one access per cycle, read data held until the next read.
module bram_be16 #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdat,
  output logic [15:0]   o_rdat
);

  logic [15:0] r_mem [0:(1<<AW)-1];
  logic [15:0] r_rdat;

  // Byte-lane writes and registered read; contents are never cleared
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdat[7:0];
      if (i_be[1]) r_mem[i_addr][15:8] <= i_wdat[15:8];
    end
    if (i_re) r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/psram_bram_responder.sv
// BRAM-backed stand-in for the PSRAM controller user port, mimicking its init and 1x/2x busy timing.
// Latency: write busy 3+LATENCY*k cycles, read busy 8+LATENCY*k cycles (k=2 after a refresh event).
// Backpressure: busy=1 during init and while a command runs; requests seen while busy are dropped.
module psram_bram_responder
  import psram_if_pkg::*;
#(
  parameter int unsigned FREQ        = 81_000_000,
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned INIT_US     = 150,
  parameter int unsigned REFRESH_CYC = 320,
  parameter int unsigned MEM_AW      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        byte_write,
  input  logic [21:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        busy,
  output logic [23:0] cnt_1x,
  output logic [23:0] cnt_2x
);

  localparam logic [23:0] INIT_LOAD = 24'(FREQ / 1_000_000 * INIT_US - 1);
  localparam int unsigned RW        = $clog2(REFRESH_CYC + 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);

  logic [1:0]        r_state;
  logic              r_busy;
  logic [23:0]       r_cnt;
  logic [15:0]       r_dout;
  logic [23:0]       r_cnt_1x;
  logic [23:0]       r_cnt_2x;
  logic              r_k2;
  logic              r_issue;
  cmd_t              r_cmd;
  logic [MEM_AW-1:0] r_waddr;
  logic [RW-1:0]     r_ref_cnt;
  logic              r_pend;

  logic              w_accept;
  logic              w_ref_pulse;
  logic              w_k2;
  logic [23:0]       w_len;
  logic              w_bram_we;
  logic              w_bram_re;
  logic [1:0]        w_be;
  logic [15:0]       w_wdat;
  logic [15:0]       w_rdat;
  logic              w_unused_addr;

  // Upper address bits are intentionally dropped so the word address wraps
  assign w_unused_addr = ^addr[21:MEM_AW+1];

  assign w_accept    = (r_state == ST_IDLE) && (read || write);
  assign w_ref_pulse = (r_ref_cnt == REF_LAST);
  // A refresh landing on the acceptance edge still forces 2x for this command
  assign w_k2        = r_pend || w_ref_pulse;
  // Write wins when both requests are raised together
  assign w_len       = busy_len(LATENCY, w_k2, write);

  // Free-running refresh timer and the pending flag it raises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref_cnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_ref_cnt <= w_ref_pulse ? '0 : r_ref_cnt + RW'(1);
      if (w_accept)         r_pend <= 1'b0;
      else if (w_ref_pulse) r_pend <= 1'b1;
    end
  end

  // Command FSM: init wait, accept, busy countdown, completion bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_busy   <= 1'b1;
      r_cnt    <= INIT_LOAD;
      r_dout   <= 16'h0000;
      r_cnt_1x <= 24'd0;
      r_cnt_2x <= 24'd0;
      r_k2     <= 1'b0;
      r_issue  <= 1'b0;
      r_cmd    <= '0;
      r_waddr  <= '0;
    end else begin
      r_issue <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_cnt == 24'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_state       <= write ? ST_WR : ST_RD;
            r_busy        <= 1'b1;
            r_cnt         <= w_len - 24'd1;
            r_k2          <= w_k2;
            r_issue       <= 1'b1;
            r_cmd.byte_wr <= byte_write;
            r_cmd.lane    <= addr[0];
            r_cmd.din     <= din;
            r_waddr       <= addr[MEM_AW:1];
          end
        end
        default: begin
          if (r_cnt == 24'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (r_state == ST_RD) r_dout <= w_rdat;
            if (r_k2) begin
              if (r_cnt_2x != 24'hFFFFFF) r_cnt_2x <= r_cnt_2x + 24'd1;
            end else begin
              if (r_cnt_1x != 24'hFFFFFF) r_cnt_1x <= r_cnt_1x + 24'd1;
            end
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
      endcase
    end
  end

  // The RAM access happens once, in the cycle right after acceptance
  assign w_bram_we = r_issue && (r_state == ST_WR);
  assign w_bram_re = r_issue && (r_state == ST_RD);
  assign w_be      = r_cmd.byte_wr ? (r_cmd.lane ? 2'b10 : 2'b01) : 2'b11;
  assign w_wdat    = r_cmd.byte_wr ? {r_cmd.din[7:0], r_cmd.din[7:0]} : r_cmd.din;

  bram_be16 #(
    .AW(MEM_AW)
  ) u_bram (
    .clk   (clk),
    .i_we  (w_bram_we),
    .i_re  (w_bram_re),
    .i_be  (w_be),
    .i_addr(r_waddr),
    .i_wdat(w_wdat),
    .o_rdat(w_rdat)
  );

  assign dout   = r_dout;
  assign busy   = r_busy;
  assign cnt_1x = r_cnt_1x;
  assign cnt_2x = r_cnt_2x;

endmodule

// File: tb/tb_psram_bram_responder.sv
// Directed plus randomized bench for psram_bram_responder against a behavioural model.
// Latency: model predicts busy length from refresh-pulse arithmetic on edge numbers.
// Backpressure: every wait on busy is bounded by a cycle budget.
module tb_psram_bram_responder;

  localparam int unsigned LAT  = 3;
  localparam int unsigned RC   = 20;
  localparam int unsigned INIT = 81 * 150;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        byte_write = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        busy;
  logic [23:0] cnt_1x;
  logic [23:0] cnt_2x;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [15:0] mem [0:4095];
  logic [15:0] exp_dout;
  int          exp_1x;
  int          exp_2x;
  int          last_e;
  int          ecount;

  psram_bram_responder #(
    .FREQ(81_000_000), .LATENCY(LAT), .INIT_US(150), .REFRESH_CYC(RC), .MEM_AW(12)
  ) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .byte_write(byte_write),
    .addr(addr), .din(din), .dout(dout), .busy(busy), .cnt_1x(cnt_1x), .cnt_2x(cnt_2x)
  );

  always #5 clk = ~clk;

  // Edge number since reset release (first edge after release is 1)
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, time its busy window and update/compare the model
  task automatic do_cmd(input bit rd, input bit wr, input bit bw, input logic [21:0] a,
                        input logic [15:0] d, input bit poke, input string tag);
    int n;
    int e;
    int exp_n;
    int w;
    bit k2;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    read = rd; write = wr; byte_write = bw; addr = a; din = d;
    e = ecount + 1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    chk({tag, "_accept"}, {31'd0, busy}, 32'd1);
    // Any refresh pulse in (previous acceptance, this acceptance] forces 2x
    k2 = (e / RC) > (last_e / RC);
    last_e = e;
    exp_n = (wr ? 3 : 8) + LAT * (k2 ? 2 : 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (poke && n == 2) begin
        write = 1'b1; addr = a ^ 22'h2; din = ~d; byte_write = 1'b0;
      end else begin
        write = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
    write = 1'b0;
    chk({tag, "_busylen"}, n, exp_n);
    w = int'(a[12:1]);
    if (wr) begin
      if (!bw)      mem[w] = d;
      else if (a[0]) mem[w][15:8] = d[7:0];
      else           mem[w][7:0]  = d[7:0];
    end else begin
      exp_dout = mem[w];
    end
    if (k2) exp_2x++; else exp_1x++;
    chk({tag, "_dout"}, {16'd0, dout}, {16'd0, exp_dout});
    chk({tag, "_cnt1x"}, {8'd0, cnt_1x}, exp_1x);
    chk({tag, "_cnt2x"}, {8'd0, cnt_2x}, exp_2x);
  endtask

  initial begin
    int n;
    int dropped;
    logic [21:0] a;
    exp_dout = 16'h0000;
    exp_1x = 0;
    exp_2x = 0;
    last_e = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_cnt1x", {8'd0, cnt_1x}, 32'd0);
    chk("rst_cnt2x", {8'd0, cnt_2x}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Init busy period length, with a request ignored along the way
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      write = (n == 100);
      addr = 22'h000004; din = 16'hFFFF;
      @(posedge clk); #1; n++;
    end
    write = 1'b0;
    chk("init_len", n, INIT);

    // Byte-lane write then word read
    do_cmd(0, 1, 0, 22'h000004, 16'h0000, 0, "w4_full");
    do_cmd(0, 1, 1, 22'h000005, 16'hC6C6, 0, "w5_byte");
    do_cmd(1, 0, 0, 22'h000004, 16'h0000, 0, "r4");
    chk("r4_c600", {16'd0, dout}, 32'h0000C600);

    // Simultaneous read and write: write wins
    do_cmd(1, 1, 0, 22'h000010, 16'h1234, 0, "rw10");
    do_cmd(1, 0, 0, 22'h000010, 16'h0000, 0, "r10");
    chk("r10_1234", {16'd0, dout}, 32'h00001234);

    // Aliased address and request while busy
    do_cmd(0, 1, 0, 22'h000002, 16'h5555, 0, "w_word1");
    do_cmd(0, 1, 0, 22'h002000, 16'hABCD, 1, "w_alias");
    do_cmd(1, 0, 0, 22'h000000, 16'h0000, 0, "r_word0");
    chk("alias_word0", {16'd0, dout}, 32'h0000ABCD);
    do_cmd(1, 0, 0, 22'h000002, 16'h0000, 0, "r_word1");
    chk("poke_ignored", {16'd0, dout}, 32'h00005555);

    // Back-to-back writes across several refresh periods
    for (int i = 0; i < 12; i++) begin
      do_cmd(0, 1, 0, 22'(2 * (i % 8)), 16'($urandom), 0, "b2b_wr");
    end

    // Randomized mix over words 0..7 with random high address bits
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      a = {9'($urandom_range(0, 511)), 9'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      do_cmd(kind == 0 || kind == 2, kind != 0, 1'($urandom_range(0, 1)), a,
             16'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    // Reset in the third busy cycle of a read
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    read = 1'b1; addr = 22'h000004;
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_dout", {16'd0, dout}, 32'd0);
    chk("abort_cnt1x", {8'd0, cnt_1x}, 32'd0);
    chk("abort_cnt2x", {8'd0, cnt_2x}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dropped = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) dropped++;
    end
    chk("reinit_busy_held", dropped, 0);
    chk("reinit_cnt1x", {8'd0, cnt_1x}, 32'd0);
    chk("reinit_cnt2x", {8'd0, cnt_2x}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
